// File: rtl/lagarto_dcache_responder.sv
// Lagarto dcache responder: serialises split-phase loads and single-phase stores onto a valid/ready memory port.
// Optional misalignment check enabled by defining LAGARTO_DCR_MISALIGN_CHK_EN.
module lagarto_dcache_responder #(
  parameter int INDEX_W = 12,
  parameter int TAG_W   = 44,
  parameter int ADDR_W  = TAG_W + INDEX_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [INDEX_W-1:0] ld_req_index_i,
  input  logic [TAG_W-1:0]  ld_req_tag_i,
  input  logic              ld_req_valid_i,
  input  logic              ld_req_tag_valid_i,
  input  logic              ld_req_kill_i,
  input  logic [1:0]        ld_req_size_i,
  input  logic [INDEX_W-1:0] st_req_index_i,
  input  logic [TAG_W-1:0]  st_req_tag_i,
  input  logic              st_req_valid_i,
  input  logic              st_req_kill_i,
  input  logic [63:0]       st_req_wdata_i,
  input  logic [7:0]        st_req_be_i,
  input  logic [1:0]        st_req_size_i,
  output logic [63:0]       resp_data_o,
  output logic              resp_valid_o,
  output logic              resp_nack_o,
  output logic              resp_gnt_st_o,
  output logic              xcpt_ma_ld_o,
  output logic              xcpt_ma_st_o,
  output logic              mem_req_valid_o,
  input  logic              mem_req_ready_i,
  output logic              mem_req_we_o,
  output logic [ADDR_W-1:0] mem_req_addr_o,
  output logic [63:0]       mem_req_wdata_o,
  output logic [7:0]        mem_req_be_o,
  input  logic              mem_resp_valid_i,
  input  logic [63:0]       mem_resp_data_i
);

  // state   | meaning
  // IDLE    | no operation outstanding, accepting requests
  // LD_TAG  | load index captured, waiting for tag phase
  // LD_REQ  | load request presented to memory
  // LD_WAIT | load accepted by memory, waiting for read data
  // ST_REQ  | store request presented to memory
  typedef enum logic [2:0] {IDLE, LD_TAG, LD_REQ, LD_WAIT, ST_REQ} state_e;

  state_e              state_q, state_d;
  logic                killed_q, killed_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [1:0]          size_q, size_d;
  logic [63:0]         wdata_q, wdata_d;
  logic [7:0]          be_q, be_d;
  logic [63:0]         resp_data_q, resp_data_d;
  logic                resp_valid_q, resp_valid_d;
  logic                nack_q, nack_d;
  logic                gnt_q, gnt_d;
  logic                xld_q, xld_d;
  logic                xst_q, xst_d;
  logic                ld_mis, st_mis;
  logic [63:0]         ld_shifted, ld_data;

`ifdef LAGARTO_DCR_MISALIGN_CHK_EN
  function automatic logic misaligned(input logic [1:0] sz, input logic [2:0] off);
    case (sz)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = off[0];
      2'd2:    misaligned = |off[1:0];
      default: misaligned = |off;
    endcase
  endfunction

  // Load offset lives in the index, so it is already latched by the tag phase.
  assign ld_mis = misaligned(size_q, paddr_q[2:0]);
  assign st_mis = misaligned(st_req_size_i, st_req_index_i[2:0]);
`else
  logic unused_st_size;
  assign unused_st_size = ^st_req_size_i;
  assign ld_mis = 1'b0;
  assign st_mis = 1'b0;
`endif

  always_comb begin
    ld_shifted = mem_resp_data_i >> {paddr_q[2:0], 3'b000};
    ld_data    = ld_shifted;
    case (size_q)
      2'd0:    ld_data = {56'd0, ld_shifted[7:0]};
      2'd1:    ld_data = {48'd0, ld_shifted[15:0]};
      2'd2:    ld_data = {32'd0, ld_shifted[31:0]};
      default: ld_data = ld_shifted;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    killed_d     = killed_q;
    paddr_d      = paddr_q;
    size_d       = size_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    resp_data_d  = resp_data_q;
    resp_valid_d = 1'b0;
    nack_d       = 1'b0;
    gnt_d        = 1'b0;
    xld_d        = 1'b0;
    xst_d        = 1'b0;
    case (state_q)
      IDLE: begin
        if (st_req_valid_i && !st_req_kill_i) begin
          paddr_d = {st_req_tag_i, st_req_index_i};
          wdata_d = st_req_wdata_i;
          be_d    = st_req_be_i;
          nack_d  = ld_req_valid_i;
          if (st_mis) xst_d = 1'b1;
          else        state_d = ST_REQ;
        end else if (ld_req_valid_i) begin
          paddr_d[INDEX_W-1:0] = ld_req_index_i;
          size_d  = ld_req_size_i;
          state_d = LD_TAG;
        end
      end
      LD_TAG: begin
        nack_d = ld_req_valid_i | st_req_valid_i;
        if (ld_req_kill_i) begin
          state_d = IDLE;
        end else if (ld_req_tag_valid_i) begin
          paddr_d[ADDR_W-1:INDEX_W] = ld_req_tag_i;
          if (ld_mis) begin
            xld_d   = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = LD_REQ;
          end
        end
      end
      LD_REQ: begin
        nack_d = ld_req_valid_i | st_req_valid_i;
        if (ld_req_kill_i) killed_d = 1'b1;
        if (mem_req_ready_i) state_d = LD_WAIT;
      end
      LD_WAIT: begin
        nack_d = ld_req_valid_i | st_req_valid_i;
        if (ld_req_kill_i) killed_d = 1'b1;
        if (mem_resp_valid_i) begin
          state_d = IDLE;
          // A kill arriving with the data still suppresses the response.
          if (!(killed_q || ld_req_kill_i)) begin
            resp_valid_d = 1'b1;
            resp_data_d  = ld_data;
          end
        end
      end
      ST_REQ: begin
        nack_d = ld_req_valid_i | st_req_valid_i;
        if (mem_req_ready_i) begin
          gnt_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d == IDLE) killed_d = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      killed_q     <= 1'b0;
      paddr_q      <= '0;
      size_q       <= 2'd0;
      wdata_q      <= 64'd0;
      be_q         <= 8'd0;
      resp_data_q  <= 64'd0;
      resp_valid_q <= 1'b0;
      nack_q       <= 1'b0;
      gnt_q        <= 1'b0;
      xld_q        <= 1'b0;
      xst_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      killed_q     <= killed_d;
      paddr_q      <= paddr_d;
      size_q       <= size_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      resp_data_q  <= resp_data_d;
      resp_valid_q <= resp_valid_d;
      nack_q       <= nack_d;
      gnt_q        <= gnt_d;
      xld_q        <= xld_d;
      xst_q        <= xst_d;
    end
  end

  assign resp_data_o     = resp_data_q;
  assign resp_valid_o    = resp_valid_q;
  assign resp_nack_o     = nack_q;
  assign resp_gnt_st_o   = gnt_q;
  assign xcpt_ma_ld_o    = xld_q;
  assign xcpt_ma_st_o    = xst_q;
  assign mem_req_valid_o = (state_q == LD_REQ) || (state_q == ST_REQ);
  assign mem_req_we_o    = (state_q == ST_REQ);
  assign mem_req_addr_o  = {paddr_q[ADDR_W-1:3], 3'b000};
  assign mem_req_wdata_o = wdata_q;
  assign mem_req_be_o    = (state_q == LD_REQ) ? 8'hFF : be_q;

endmodule

// File: tb/tb_lagarto_dcache_responder.sv
// Directed bench for lagarto_dcache_responder; misalignment steps follow LAGARTO_DCR_MISALIGN_CHK_EN.
module tb_lagarto_dcache_responder;
  localparam int INDEX_W = 12;
  localparam int TAG_W   = 44;
  localparam int ADDR_W  = TAG_W + INDEX_W;

  logic clk, rst;
  logic [INDEX_W-1:0] ld_idx, st_idx;
  logic [TAG_W-1:0] ld_tag, st_tag;
  logic ld_valid, ld_tag_valid, ld_kill, st_valid, st_kill;
  logic [1:0] ld_size, st_size;
  logic [63:0] st_wdata, mem_rdata;
  logic [7:0] st_be;
  logic mem_ready, mem_rvalid;
  logic [63:0] resp_data;
  logic resp_valid, resp_nack, resp_gnt, xld, xst;
  logic mreq_valid, mreq_we;
  logic [ADDR_W-1:0] mreq_addr;
  logic [63:0] mreq_wdata;
  logic [7:0] mreq_be;

  int n_cmp = 0;
  int n_fail = 0;

  lagarto_dcache_responder #(.INDEX_W(INDEX_W), .TAG_W(TAG_W)) dut (
    .clk_i(clk), .rst_i(rst),
    .ld_req_index_i(ld_idx), .ld_req_tag_i(ld_tag),
    .ld_req_valid_i(ld_valid), .ld_req_tag_valid_i(ld_tag_valid),
    .ld_req_kill_i(ld_kill), .ld_req_size_i(ld_size),
    .st_req_index_i(st_idx), .st_req_tag_i(st_tag),
    .st_req_valid_i(st_valid), .st_req_kill_i(st_kill),
    .st_req_wdata_i(st_wdata), .st_req_be_i(st_be), .st_req_size_i(st_size),
    .resp_data_o(resp_data), .resp_valid_o(resp_valid), .resp_nack_o(resp_nack),
    .resp_gnt_st_o(resp_gnt), .xcpt_ma_ld_o(xld), .xcpt_ma_st_o(xst),
    .mem_req_valid_o(mreq_valid), .mem_req_ready_i(mem_ready),
    .mem_req_we_o(mreq_we), .mem_req_addr_o(mreq_addr),
    .mem_req_wdata_o(mreq_wdata), .mem_req_be_o(mreq_be),
    .mem_resp_valid_i(mem_rvalid), .mem_resp_data_i(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outs(input string tag);
    chk1({tag, "_rv"}, resp_valid, 1'b0);
    chk1({tag, "_nack"}, resp_nack, 1'b0);
    chk1({tag, "_gnt"}, resp_gnt, 1'b0);
    chk1({tag, "_mv"}, mreq_valid, 1'b0);
  endtask

  task automatic clear_in();
    ld_idx = '0; ld_tag = '0; ld_valid = 0; ld_tag_valid = 0; ld_kill = 0; ld_size = 0;
    st_idx = '0; st_tag = '0; st_valid = 0; st_kill = 0; st_wdata = 0; st_be = 0; st_size = 0;
    mem_ready = 0; mem_rvalid = 0; mem_rdata = 0;
  endtask

  initial begin
    clear_in();
    rst = 1;
    tick(); tick();
    // reset state
    chk_idle_outs("rst");
    chk64("rst_data", resp_data, 64'd0);
    chk64("rst_addr", 64'(mreq_addr), 64'd0);
    chk1("rst_we", mreq_we, 1'b0);
    chk64("rst_be", 64'(mreq_be), 64'd0);
    chk64("rst_wdata", mreq_wdata, 64'd0);
    chk1("rst_xld", xld, 1'b0);
    chk1("rst_xst", xst, 1'b0);
    rst = 0;
    tick();

    // LD at 0x1010, minimum latency
    ld_valid = 1; ld_idx = 12'h010; ld_size = 2'd3;
    tick();
    ld_valid = 0; ld_tag_valid = 1; ld_tag = 44'h1;
    chk1("ld_c1_mv", mreq_valid, 1'b0);
    tick();
    ld_tag_valid = 0; mem_ready = 1;
    chk1("ld_c2_mv", mreq_valid, 1'b1);
    chk1("ld_c2_we", mreq_we, 1'b0);
    chk64("ld_c2_addr", 64'(mreq_addr), 64'h1010);
    chk64("ld_c2_be", 64'(mreq_be), 64'hFF);
    tick();
    mem_ready = 0; mem_rvalid = 1; mem_rdata = 64'h1122334455667788;
    chk1("ld_c3_mv", mreq_valid, 1'b0);
    chk1("ld_c3_rv", resp_valid, 1'b0);
    tick();
    mem_rvalid = 0;
    chk1("ld_c4_rv", resp_valid, 1'b1);
    chk64("ld_c4_data", resp_data, 64'h1122334455667788);
    tick();
    chk1("ld_c5_rv", resp_valid, 1'b0);

    // LB at paddr 0x2013 -> byte 3 = 0x55
    ld_valid = 1; ld_idx = 12'h013; ld_size = 2'd0;
    tick();
    ld_valid = 0; ld_tag_valid = 1; ld_tag = 44'h2;
    tick();
    ld_tag_valid = 0; mem_ready = 1;
    chk64("lb_addr", 64'(mreq_addr), 64'h2010);
    tick();
    mem_ready = 0; mem_rvalid = 1; mem_rdata = 64'h1122334455667788;
    tick();
    mem_rvalid = 0;
    chk1("lb_rv", resp_valid, 1'b1);
    chk64("lb_data", resp_data, 64'h55);
    tick();

    // store with back-pressure
    st_valid = 1; st_idx = 12'h028; st_tag = 44'h3; st_size = 2'd2;
    st_wdata = 64'hDEADBEEFCAFEF00D; st_be = 8'h0F;
    tick();
    clear_in();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) mem_ready = 1;
      chk1("st_wait_mv", mreq_valid, 1'b1);
      chk1("st_wait_we", mreq_we, 1'b1);
      chk64("st_wait_addr", 64'(mreq_addr), 64'h3028);
      chk64("st_wait_wdata", mreq_wdata, 64'hDEADBEEFCAFEF00D);
      chk64("st_wait_be", 64'(mreq_be), 64'h0F);
      chk1("st_wait_gnt", resp_gnt, 1'b0);
      tick();
    end
    mem_ready = 0;
    chk1("st_gnt", resp_gnt, 1'b1);
    chk1("st_gnt_mv", mreq_valid, 1'b0);
    tick();
    chk1("st_gnt_end", resp_gnt, 1'b0);

    // load killed in LD_WAIT
    ld_valid = 1; ld_idx = 12'h020; ld_size = 2'd3;
    tick();
    ld_valid = 0; ld_tag_valid = 1; ld_tag = 44'h4;
    tick();
    ld_tag_valid = 0; mem_ready = 1;
    tick();
    mem_ready = 0; ld_kill = 1;
    tick();
    ld_kill = 0; mem_rvalid = 1; mem_rdata = 64'hFFFF0000FFFF0000;
    tick();
    mem_rvalid = 0;
    chk1("kill_rv", resp_valid, 1'b0);
    // following LW at 0x5030 completes normally
    ld_valid = 1; ld_idx = 12'h030; ld_size = 2'd2;
    tick();
    ld_valid = 0; ld_tag_valid = 1; ld_tag = 44'h5;
    chk1("kill_c6_rv", resp_valid, 1'b0);
    tick();
    ld_tag_valid = 0; mem_ready = 1;
    chk64("post_kill_addr", 64'(mreq_addr), 64'h5030);
    tick();
    mem_ready = 0; mem_rvalid = 1; mem_rdata = 64'hAABBCCDD11223344;
    tick();
    mem_rvalid = 0;
    chk1("post_kill_rv", resp_valid, 1'b1);
    chk64("post_kill_data", resp_data, 64'h11223344);
    tick();

    // store and load together, then another load during ST_REQ
    st_valid = 1; st_idx = 12'h040; st_tag = 44'h6; st_size = 2'd3;
    st_wdata = 64'h0123456789ABCDEF; st_be = 8'hFF;
    ld_valid = 1; ld_idx = 12'h050; ld_size = 2'd3;
    tick();
    st_valid = 0;
    chk1("sl_c1_nack", resp_nack, 1'b1);
    chk1("sl_c1_we", mreq_we, 1'b1);
    chk64("sl_c1_addr", 64'(mreq_addr), 64'h6040);
    tick();
    ld_valid = 0; mem_ready = 1;
    chk1("sl_c2_nack", resp_nack, 1'b1);
    tick();
    mem_ready = 0;
    chk1("sl_c3_gnt", resp_gnt, 1'b1);
    chk1("sl_c3_nack", resp_nack, 1'b0);
    tick();
    chk_idle_outs("sl_c4");

    // stray memory response in IDLE
    mem_rvalid = 1; mem_rdata = 64'h5A5A5A5A5A5A5A5A;
    tick();
    mem_rvalid = 0;
    chk1("stray_rv", resp_valid, 1'b0);

    // kill in LD_TAG: no memory request
    ld_valid = 1; ld_idx = 12'h070; ld_size = 2'd3;
    tick();
    ld_valid = 0; ld_kill = 1;
    tick();
    ld_kill = 0;
    chk1("tagkill_mv", mreq_valid, 1'b0);
    tick();
    chk_idle_outs("tagkill");

    // reset while in LD_WAIT
    ld_valid = 1; ld_idx = 12'h060; ld_size = 2'd3;
    tick();
    ld_valid = 0; ld_tag_valid = 1; ld_tag = 44'h7;
    tick();
    ld_tag_valid = 0; mem_ready = 1;
    tick();
    mem_ready = 0; rst = 1;
    tick();
    rst = 0; mem_rvalid = 1; mem_rdata = 64'h1111111111111111;
    chk64("mid_rst_addr", 64'(mreq_addr), 64'd0);
    chk1("mid_rst_mv", mreq_valid, 1'b0);
    tick();
    mem_rvalid = 0;
    chk1("mid_rst_rv", resp_valid, 1'b0);
    chk64("mid_rst_data", resp_data, 64'd0);

    // LW at 0x1002
    ld_valid = 1; ld_idx = 12'h002; ld_size = 2'd2;
    tick();
    ld_valid = 0; ld_tag_valid = 1; ld_tag = 44'h1;
    tick();
    ld_tag_valid = 0;
`ifdef LAGARTO_DCR_MISALIGN_CHK_EN
    chk1("ma_ld_x", xld, 1'b1);
    chk1("ma_ld_mv", mreq_valid, 1'b0);
    tick();
    chk1("ma_ld_x_end", xld, 1'b0);
    chk1("ma_ld_mv2", mreq_valid, 1'b0);
    // SH at 0x1001
    st_valid = 1; st_idx = 12'h001; st_tag = 44'h1; st_size = 2'd1; st_be = 8'h06;
    tick();
    st_valid = 0;
    chk1("ma_st_x", xst, 1'b1);
    chk1("ma_st_mv", mreq_valid, 1'b0);
    tick();
    chk1("ma_st_x_end", xst, 1'b0);
    chk1("ma_st_mv2", mreq_valid, 1'b0);
`else
    mem_ready = 1;
    chk1("ma_ld_x", xld, 1'b0);
    chk1("ma_ld_mv", mreq_valid, 1'b1);
    chk64("ma_ld_addr", 64'(mreq_addr), 64'h1000);
    tick();
    mem_ready = 0; mem_rvalid = 1; mem_rdata = 64'h1122334455667788;
    tick();
    mem_rvalid = 0;
    chk1("ma_ld_rv", resp_valid, 1'b1);
    chk64("ma_ld_data", resp_data, 64'h33445566);
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
